// File: rtl/spark_pwm_responder.sv
// Servo-style PWM generator for the Spark motor controller with a
// request/acknowledge handshake toward the PID block.
//
// Ports:
//   clock, reset   : main clock; synchronous active-high reset
//   pwm_enable     : 1 = generate frames, 0 = output held low
//   pwm_update     : one-cycle request to take pwm_ratio/pwm_direction
//   pwm_ratio      : command magnitude 0..255
//   pwm_direction  : 1 = forward (above neutral), 0 = reverse
//   pwm_done       : one-cycle acknowledge, requested value now active
//   pwm_pending    : request latched, waiting for the frame boundary
//   pwm_signal     : registered pulse train to the motor controller
module spark_pwm_responder #(
  parameter int CLKS_PER_US = 50,
  parameter int PERIOD_US   = 20000,
  parameter int NEUTRAL_US  = 1500,
  parameter int SPAN_US     = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pwm_enable,
  input  logic       pwm_update,
  input  logic [7:0] pwm_ratio,
  input  logic       pwm_direction,
  output logic       pwm_done,
  output logic       pwm_pending,
  output logic       pwm_signal
);

  localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam int UW = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam int HW = $clog2(NEUTRAL_US + SPAN_US + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_US - 1);
  localparam logic [UW-1:0] US_LAST  = UW'(PERIOD_US - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic [UW-1:0] us_count;
  logic [7:0]    active_ratio;
  logic          active_dir;
  logic [7:0]    pend_ratio;
  logic          pend_dir;

  logic [31:0]   prod;
  logic [31:0]   offset_us;
  logic [31:0]   high_full;
  logic [HW-1:0] high_us;
  logic          pre_wrap;
  logic          frame_end;
  logic          below_high;

  // Pulse width is derived from the active command only, so a latched
  // but not yet applied request never disturbs the frame in progress.
  always_comb begin
    prod      = {24'd0, active_ratio} * 32'(SPAN_US);
    offset_us = prod >> 8;
    high_full = 32'(NEUTRAL_US);
    if (active_dir) begin
      high_full = 32'(NEUTRAL_US) + offset_us;
    end else begin
      high_full = 32'(NEUTRAL_US) - offset_us;
    end
    high_us    = HW'(high_full);
    pre_wrap   = (prescaler == PRE_LAST);
    frame_end  = pre_wrap && (us_count == US_LAST);
    below_high = (32'(us_count) < 32'(high_us));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      prescaler    <= '0;
      us_count     <= '0;
      active_ratio <= '0;
      active_dir   <= 1'b0;
      pend_ratio   <= '0;
      pend_dir     <= 1'b0;
      pwm_done     <= 1'b0;
      pwm_pending  <= 1'b0;
      pwm_signal   <= 1'b0;
    end else begin
      pwm_done <= 1'b0;
      unique case (state)
        IDLE: begin
          prescaler  <= '0;
          us_count   <= '0;
          pwm_signal <= 1'b0;
          // While disabled there is no frame to wait for, so a request
          // is applied at once to keep the PID side from stalling.
          if (pwm_update) begin
            active_ratio <= pwm_ratio;
            active_dir   <= pwm_direction;
            pwm_done     <= 1'b1;
          end
          if (pwm_enable) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!pwm_enable) begin
            // Abandon the partial frame; flush any waiting request so
            // the acknowledge lands on the first idle cycle.
            state       <= IDLE;
            prescaler   <= '0;
            us_count    <= '0;
            pwm_signal  <= 1'b0;
            pwm_pending <= 1'b0;
            if (pwm_update) begin
              active_ratio <= pwm_ratio;
              active_dir   <= pwm_direction;
              pwm_done     <= 1'b1;
            end else if (pwm_pending) begin
              active_ratio <= pend_ratio;
              active_dir   <= pend_dir;
              pwm_done     <= 1'b1;
            end
          end else begin
            pwm_signal <= below_high;
            if (pre_wrap) begin
              prescaler <= '0;
              if (us_count == US_LAST) begin
                us_count <= '0;
              end else begin
                us_count <= us_count + UW'(1);
              end
            end else begin
              prescaler <= prescaler + PW'(1);
            end
            if (frame_end) begin
              // A request arriving on the boundary itself bypasses
              // the pending registers.
              pwm_pending <= 1'b0;
              if (pwm_update) begin
                active_ratio <= pwm_ratio;
                active_dir   <= pwm_direction;
                pwm_done     <= 1'b1;
              end else if (pwm_pending) begin
                active_ratio <= pend_ratio;
                active_dir   <= pend_dir;
                pwm_done     <= 1'b1;
              end
            end else if (pwm_update) begin
              pend_ratio  <= pwm_ratio;
              pend_dir    <= pwm_direction;
              pwm_pending <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spark_pwm_responder.sv
// Bench for spark_pwm_responder: expected acknowledge cycles and pulse
// widths are queued by the stimulus and checked by independent monitors.
module tb_spark_pwm_responder;

  localparam int CPU = 2;
  localparam int PER = 2500;
  localparam int NEU = 1500;
  localparam int SPN = 500;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pwm_enable = 1'b0;
  logic       pwm_update = 1'b0;
  logic [7:0] pwm_ratio = 8'd0;
  logic       pwm_direction = 1'b0;
  logic       pwm_done;
  logic       pwm_pending;
  logic       pwm_signal;

  int cyc = 0;
  int vecs = 0;
  int errs = 0;
  int run_len = 0;
  int done_q[$];
  int pulse_q[$];

  spark_pwm_responder #(
    .CLKS_PER_US(CPU),
    .PERIOD_US  (PER),
    .NEUTRAL_US (NEU),
    .SPAN_US    (SPN)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pwm_enable   (pwm_enable),
    .pwm_update   (pwm_update),
    .pwm_ratio    (pwm_ratio),
    .pwm_direction(pwm_direction),
    .pwm_done     (pwm_done),
    .pwm_pending  (pwm_pending),
    .pwm_signal   (pwm_signal)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, got, exp, cyc);
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic upd(input logic [7:0] r, input logic d);
    pwm_ratio     = r;
    pwm_direction = d;
    pwm_update    = 1'b1;
    goto(cyc + 1);
    pwm_update    = 1'b0;
  endtask

  // Acknowledge monitor: each pwm_done must match the next expected cycle.
  always @(negedge clock) begin
    if (pwm_done === 1'b1) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", cyc, -1);
      end else begin
        chk("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  // Pulse monitor: every completed high run must match the next width.
  always @(negedge clock) begin
    if (pwm_signal === 1'b1) begin
      run_len++;
    end else if (run_len > 0) begin
      if (pulse_q.size() == 0) begin
        chk("pulse_unexpected", run_len, -1);
      end else begin
        chk("pulse_width", run_len, pulse_q.pop_front());
      end
      run_len = 0;
    end
  end

  initial begin
    goto(2);
    chk("rst_signal", int'(pwm_signal), 0);
    chk("rst_done", int'(pwm_done), 0);
    chk("rst_pending", int'(pwm_pending), 0);
    goto(3);
    reset = 1'b0;

    // Neutral frames starting at cycles 6 and 5006.
    goto(5);
    pulse_q.push_back(3000);
    pulse_q.push_back(3000);
    pwm_enable = 1'b1;

    // Full forward mid-frame: applied at frame start 10006.
    goto(6006);
    done_q.push_back(10006);
    pulse_q.push_back(3996);
    pulse_q.push_back(3996);
    upd(8'd255, 1'b1);
    goto(6008);
    chk("pend_after_upd", int'(pwm_pending), 1);
    goto(10005);
    chk("pend_before_edge", int'(pwm_pending), 1);
    goto(10006);
    chk("pend_after_edge", int'(pwm_pending), 0);

    // Two requests in one frame: last wins at 20006.
    goto(15106);
    done_q.push_back(20006);
    pulse_q.push_back(2500);
    upd(8'd10, 1'b1);
    goto(15206);
    upd(8'd128, 1'b0);
    goto(15300);
    chk("pend_two_upd", int'(pwm_pending), 1);

    // Disable after the pulse, then request while idle.
    goto(23006);
    pwm_enable = 1'b0;
    goto(23010);
    done_q.push_back(23011);
    upd(8'd64, 1'b1);
    goto(23012);
    chk("idle_signal", int'(pwm_signal), 0);
    chk("idle_pending", int'(pwm_pending), 0);

    // Re-enable: frame 23021 uses the idle-loaded command.
    goto(23020);
    pulse_q.push_back(3250);
    pwm_enable = 1'b1;

    // Request on the frame_end cycle of frame 23021.
    goto(28020);
    done_q.push_back(28021);
    pulse_q.push_back(2220);
    upd(8'd200, 1'b0);
    chk("coinc_pending0", int'(pwm_pending), 0);
    goto(28022);
    chk("coinc_pending1", int'(pwm_pending), 0);

    // Frame 33021: request pending, disable at us_count=700.
    goto(33121);
    pulse_q.push_back(1400);
    done_q.push_back(34422);
    upd(8'd64, 1'b1);
    goto(34421);
    chk("pend_before_dis", int'(pwm_pending), 1);
    pwm_enable = 1'b0;
    goto(34422);
    chk("dis_signal", int'(pwm_signal), 0);
    chk("dis_pending", int'(pwm_pending), 0);

    // Frame 34431: reset at us_count=1000 with a request pending.
    goto(34430);
    pulse_q.push_back(2000);
    pwm_enable = 1'b1;
    goto(34481);
    upd(8'd255, 1'b1);
    goto(36431);
    chk("pend_before_rst", int'(pwm_pending), 1);
    reset      = 1'b1;
    pwm_enable = 1'b0;
    goto(36432);
    chk("rstm_signal", int'(pwm_signal), 0);
    chk("rstm_done", int'(pwm_done), 0);
    chk("rstm_pending", int'(pwm_pending), 0);
    goto(36434);
    reset = 1'b0;

    // After reset the command is neutral again.
    goto(36440);
    pulse_q.push_back(3000);
    pwm_enable = 1'b1;

    goto(39941);
    chk("done_left", done_q.size(), 0);
    chk("pulse_left", pulse_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
